// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared types and constants for the instruction fetch unit.
// Revision : 1.0
// ============================================================================
package ifetch_pkg;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small register FIFO buffering {pc, instr} pairs; flush wins.
// Revision : 1.0
// ============================================================================
module fetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   output fetch_entry_t             head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // A push into a full buffer is only legal when the head leaves the same cycle.
   assign do_push = push & ~flush & (~full | pop);
   assign do_pop  = pop  & ~flush & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_unit
// Purpose  : Fetch PC, redirect/halt FSM and instruction buffer to decode.
// Revision : 1.0
// ============================================================================
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 6
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_read_data,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               instr_valid,
   output logic [31:0]        instr,
   output logic [31:0]        instr_pc,
   input  logic               instr_ready,
   output logic               fetch_err
);

   fetch_state_t               state_q, state_d;
   logic [31:0]                fetch_pc_q, fetch_pc_d;
   logic                       push;
   logic                       pop;
   logic                       space;
   logic                       fifo_empty;
   logic                       fifo_full;
   logic [$clog2(DEPTH):0]     fifo_count;
   fetch_entry_t               push_data;
   fetch_entry_t               head_data;

   assign imem_addr   = fetch_pc_q[IMEM_AW+1:2];
   assign instr_valid = (fifo_count != '0);
   assign pop         = instr_ready & ~fifo_empty;
   assign space       = ~fifo_full | pop;
   assign push_data   = '{pc: fetch_pc_q, instr: imem_read_data};
   assign instr       = head_data.instr;
   assign instr_pc    = head_data.pc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // A misaligned target parks the unit in HALT until an aligned redirect.
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = (redirect_pc[1:0] != 2'b00) ? HALT : RUN;
      end
   end

   always_comb begin
      fetch_err = (state_q == HALT);
      push      = (state_q == RUN) & ~redirect_valid & space;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + INSTR_BYTES;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_unit
// Purpose  : Randomized bench for ifetch_unit against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_ifetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          IMEM_AW  = 6;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_read_data;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               instr_valid;
   logic [31:0]        instr;
   logic [31:0]        instr_pc;
   logic               instr_ready;
   logic               fetch_err;

   logic [31:0] imem [64];
   logic [63:0] m_q [$];
   logic [31:0] m_pc;
   bit          m_halt;
   int          n_chk  = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   assign imem_read_data = imem[imem_addr];

   ifetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC),
      .IMEM_AW  (IMEM_AW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_addr      (imem_addr),
      .imem_read_data (imem_read_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .fetch_err      (fetch_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
   endtask

   task automatic check_outputs();
      logic [63:0] head;
      chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
      chk("imem_addr",   32'(imem_addr),   32'(m_pc[7:2]));
      chk("fetch_err",   32'(fetch_err),   32'(m_halt));
      if (m_q.size() != 0) begin
         head = m_q[0];
         chk("instr_pc", instr_pc, head[63:32]);
         chk("instr",    instr,    head[31:0]);
      end
   endtask

   // One clock edge of the reference behaviour, using the inputs just driven.
   task automatic model_edge(input bit rdy, input bit rv, input logic [31:0] rpc);
      bit popped;
      bit has_space;
      if (rv) begin
         m_q.delete();
         m_pc   = rpc;
         m_halt = (rpc[1:0] != 2'b00);
      end else begin
         popped    = rdy && (m_q.size() > 0);
         has_space = (m_q.size() < DEPTH) || popped;
         if (popped) void'(m_q.pop_front());
         if (!m_halt && has_space) begin
            m_q.push_back({m_pc, imem[m_pc[7:2]]});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
      check_outputs();
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      model_edge(rdy, rv, rpc);
      @(negedge clk);
   endtask

   task automatic steps(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(rdy, 1'b0, 32'h0);
   endtask

   // Reset asserted between edges must clear the outputs without a clock.
   task automatic async_reset_pulse();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      @(posedge clk);
      model_edge(1'b0, 1'b0, 32'h0);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(instr_valid), 32'h0);
      chk("async_rst_err",   32'(fetch_err),   32'h0);
      chk("async_rst_addr",  32'(imem_addr),   32'(RESET_PC[7:2]));
      @(negedge clk);
      model_reset();
      reset_n = 1'b1;
   endtask

   initial begin
      logic [31:0] rpc;
      imem[0] = 32'h00000013;
      imem[1] = 32'h00100093;
      imem[2] = 32'h00200113;
      imem[3] = 32'h00300193;
      imem[4] = 32'h00400213;
      for (int i = 5; i < 64; i++) imem[i] = $urandom;

      reset_n        = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_valid", 32'(instr_valid), 32'h0);
      chk("reset_err",   32'(fetch_err),   32'h0);
      chk("reset_addr",  32'(imem_addr),   32'h0);
      reset_n = 1'b1;

      steps(5, 1'b1);
      steps(6, 1'b0);
      steps(6, 1'b1);
      steps(3, 1'b0);
      step(1'b1, 1'b1, 32'h40);
      chk("redir_flush", 32'(instr_valid), 32'h0);
      steps(3, 1'b1);
      step(1'b1, 1'b1, 32'h42);
      steps(10, 1'b1);
      step(1'b1, 1'b1, 32'h10);
      steps(3, 1'b1);
      async_reset_pulse();
      steps(3, 1'b1);
      step(1'b1, 1'b1, 32'h42);
      steps(2, 1'b1);
      async_reset_pulse();
      steps(2, 1'b1);
      step(1'b1, 1'b1, 32'hFC);
      steps(4, 1'b1);
      step(1'b1, 1'b1, 32'hFFFF_FFF8);
      steps(4, 1'b1);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
            step(1'($urandom_range(0, 1)), 1'b1, rpc);
         end else begin
            step(($urandom_range(0, 3) != 0), 1'b0, 32'h0);
         end
      end
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
